inv_substitute_state: RTL and testbench

INV_SUBSTITUTE_STATE -- requirements
Module: inv_substitute_state

---
 rtl/inv_substitute_state_pkg.sv | 40 ++++
 rtl/inv_substitute_state_inv_sbox.sv | 78 +++++++
 rtl/inv_substitute_state.sv | 96 +++++++++
 tb/tb_inv_substitute_state.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/inv_substitute_state_pkg.sv
// Shared AES package: FSM state encoding, state geometry and the forward S-box.
package inv_substitute_state_pkg;

  localparam int STATE_BYTES = 16;
  localparam int BYTE_W      = 8;
  localparam int STATE_W     = STATE_BYTES * BYTE_W;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } inv_sub_state_e;

  // Forward S-box, entry 0x00 in the most significant byte, entry 0xff in the least.
  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Forward S-box lookup, used by the key-schedule / encrypt side of the core.
  function automatic logic [BYTE_W-1:0] fwd_sbox(input logic [BYTE_W-1:0] b);
    return FWD_SBOX[(255 - int'(b)) * BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/inv_substitute_state_inv_sbox.sv
// Combinational AES inverse S-box, one byte in, one byte out.
module inv_sbox_LUT (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Full 256-entry inverse substitution table.
  always_comb begin
    o_byte = 8'h00;
    case (i_byte)
      8'h00: o_byte = 8'h52; 8'h01: o_byte = 8'h09; 8'h02: o_byte = 8'h6a; 8'h03: o_byte = 8'hd5;
      8'h04: o_byte = 8'h30; 8'h05: o_byte = 8'h36; 8'h06: o_byte = 8'ha5; 8'h07: o_byte = 8'h38;
      8'h08: o_byte = 8'hbf; 8'h09: o_byte = 8'h40; 8'h0a: o_byte = 8'ha3; 8'h0b: o_byte = 8'h9e;
      8'h0c: o_byte = 8'h81; 8'h0d: o_byte = 8'hf3; 8'h0e: o_byte = 8'hd7; 8'h0f: o_byte = 8'hfb;
      8'h10: o_byte = 8'h7c; 8'h11: o_byte = 8'he3; 8'h12: o_byte = 8'h39; 8'h13: o_byte = 8'h82;
      8'h14: o_byte = 8'h9b; 8'h15: o_byte = 8'h2f; 8'h16: o_byte = 8'hff; 8'h17: o_byte = 8'h87;
      8'h18: o_byte = 8'h34; 8'h19: o_byte = 8'h8e; 8'h1a: o_byte = 8'h43; 8'h1b: o_byte = 8'h44;
      8'h1c: o_byte = 8'hc4; 8'h1d: o_byte = 8'hde; 8'h1e: o_byte = 8'he9; 8'h1f: o_byte = 8'hcb;
      8'h20: o_byte = 8'h54; 8'h21: o_byte = 8'h7b; 8'h22: o_byte = 8'h94; 8'h23: o_byte = 8'h32;
      8'h24: o_byte = 8'ha6; 8'h25: o_byte = 8'hc2; 8'h26: o_byte = 8'h23; 8'h27: o_byte = 8'h3d;
      8'h28: o_byte = 8'hee; 8'h29: o_byte = 8'h4c; 8'h2a: o_byte = 8'h95; 8'h2b: o_byte = 8'h0b;
      8'h2c: o_byte = 8'h42; 8'h2d: o_byte = 8'hfa; 8'h2e: o_byte = 8'hc3; 8'h2f: o_byte = 8'h4e;
      8'h30: o_byte = 8'h08; 8'h31: o_byte = 8'h2e; 8'h32: o_byte = 8'ha1; 8'h33: o_byte = 8'h66;
      8'h34: o_byte = 8'h28; 8'h35: o_byte = 8'hd9; 8'h36: o_byte = 8'h24; 8'h37: o_byte = 8'hb2;
      8'h38: o_byte = 8'h76; 8'h39: o_byte = 8'h5b; 8'h3a: o_byte = 8'ha2; 8'h3b: o_byte = 8'h49;
      8'h3c: o_byte = 8'h6d; 8'h3d: o_byte = 8'h8b; 8'h3e: o_byte = 8'hd1; 8'h3f: o_byte = 8'h25;
      8'h40: o_byte = 8'h72; 8'h41: o_byte = 8'hf8; 8'h42: o_byte = 8'hf6; 8'h43: o_byte = 8'h64;
      8'h44: o_byte = 8'h86; 8'h45: o_byte = 8'h68; 8'h46: o_byte = 8'h98; 8'h47: o_byte = 8'h16;
      8'h48: o_byte = 8'hd4; 8'h49: o_byte = 8'ha4; 8'h4a: o_byte = 8'h5c; 8'h4b: o_byte = 8'hcc;
      8'h4c: o_byte = 8'h5d; 8'h4d: o_byte = 8'h65; 8'h4e: o_byte = 8'hb6; 8'h4f: o_byte = 8'h92;
      8'h50: o_byte = 8'h6c; 8'h51: o_byte = 8'h70; 8'h52: o_byte = 8'h48; 8'h53: o_byte = 8'h50;
      8'h54: o_byte = 8'hfd; 8'h55: o_byte = 8'hed; 8'h56: o_byte = 8'hb9; 8'h57: o_byte = 8'hda;
      8'h58: o_byte = 8'h5e; 8'h59: o_byte = 8'h15; 8'h5a: o_byte = 8'h46; 8'h5b: o_byte = 8'h57;
      8'h5c: o_byte = 8'ha7; 8'h5d: o_byte = 8'h8d; 8'h5e: o_byte = 8'h9d; 8'h5f: o_byte = 8'h84;
      8'h60: o_byte = 8'h90; 8'h61: o_byte = 8'hd8; 8'h62: o_byte = 8'hab; 8'h63: o_byte = 8'h00;
      8'h64: o_byte = 8'h8c; 8'h65: o_byte = 8'hbc; 8'h66: o_byte = 8'hd3; 8'h67: o_byte = 8'h0a;
      8'h68: o_byte = 8'hf7; 8'h69: o_byte = 8'he4; 8'h6a: o_byte = 8'h58; 8'h6b: o_byte = 8'h05;
      8'h6c: o_byte = 8'hb8; 8'h6d: o_byte = 8'hb3; 8'h6e: o_byte = 8'h45; 8'h6f: o_byte = 8'h06;
      8'h70: o_byte = 8'hd0; 8'h71: o_byte = 8'h2c; 8'h72: o_byte = 8'h1e; 8'h73: o_byte = 8'h8f;
      8'h74: o_byte = 8'hca; 8'h75: o_byte = 8'h3f; 8'h76: o_byte = 8'h0f; 8'h77: o_byte = 8'h02;
      8'h78: o_byte = 8'hc1; 8'h79: o_byte = 8'haf; 8'h7a: o_byte = 8'hbd; 8'h7b: o_byte = 8'h03;
      8'h7c: o_byte = 8'h01; 8'h7d: o_byte = 8'h13; 8'h7e: o_byte = 8'h8a; 8'h7f: o_byte = 8'h6b;
      8'h80: o_byte = 8'h3a; 8'h81: o_byte = 8'h91; 8'h82: o_byte = 8'h11; 8'h83: o_byte = 8'h41;
      8'h84: o_byte = 8'h4f; 8'h85: o_byte = 8'h67; 8'h86: o_byte = 8'hdc; 8'h87: o_byte = 8'hea;
      8'h88: o_byte = 8'h97; 8'h89: o_byte = 8'hf2; 8'h8a: o_byte = 8'hcf; 8'h8b: o_byte = 8'hce;
      8'h8c: o_byte = 8'hf0; 8'h8d: o_byte = 8'hb4; 8'h8e: o_byte = 8'he6; 8'h8f: o_byte = 8'h73;
      8'h90: o_byte = 8'h96; 8'h91: o_byte = 8'hac; 8'h92: o_byte = 8'h74; 8'h93: o_byte = 8'h22;
      8'h94: o_byte = 8'he7; 8'h95: o_byte = 8'had; 8'h96: o_byte = 8'h35; 8'h97: o_byte = 8'h85;
      8'h98: o_byte = 8'he2; 8'h99: o_byte = 8'hf9; 8'h9a: o_byte = 8'h37; 8'h9b: o_byte = 8'he8;
      8'h9c: o_byte = 8'h1c; 8'h9d: o_byte = 8'h75; 8'h9e: o_byte = 8'hdf; 8'h9f: o_byte = 8'h6e;
      8'ha0: o_byte = 8'h47; 8'ha1: o_byte = 8'hf1; 8'ha2: o_byte = 8'h1a; 8'ha3: o_byte = 8'h71;
      8'ha4: o_byte = 8'h1d; 8'ha5: o_byte = 8'h29; 8'ha6: o_byte = 8'hc5; 8'ha7: o_byte = 8'h89;
      8'ha8: o_byte = 8'h6f; 8'ha9: o_byte = 8'hb7; 8'haa: o_byte = 8'h62; 8'hab: o_byte = 8'h0e;
      8'hac: o_byte = 8'haa; 8'had: o_byte = 8'h18; 8'hae: o_byte = 8'hbe; 8'haf: o_byte = 8'h1b;
      8'hb0: o_byte = 8'hfc; 8'hb1: o_byte = 8'h56; 8'hb2: o_byte = 8'h3e; 8'hb3: o_byte = 8'h4b;
      8'hb4: o_byte = 8'hc6; 8'hb5: o_byte = 8'hd2; 8'hb6: o_byte = 8'h79; 8'hb7: o_byte = 8'h20;
      8'hb8: o_byte = 8'h9a; 8'hb9: o_byte = 8'hdb; 8'hba: o_byte = 8'hc0; 8'hbb: o_byte = 8'hfe;
      8'hbc: o_byte = 8'h78; 8'hbd: o_byte = 8'hcd; 8'hbe: o_byte = 8'h5a; 8'hbf: o_byte = 8'hf4;
      8'hc0: o_byte = 8'h1f; 8'hc1: o_byte = 8'hdd; 8'hc2: o_byte = 8'ha8; 8'hc3: o_byte = 8'h33;
      8'hc4: o_byte = 8'h88; 8'hc5: o_byte = 8'h07; 8'hc6: o_byte = 8'hc7; 8'hc7: o_byte = 8'h31;
      8'hc8: o_byte = 8'hb1; 8'hc9: o_byte = 8'h12; 8'hca: o_byte = 8'h10; 8'hcb: o_byte = 8'h59;
      8'hcc: o_byte = 8'h27; 8'hcd: o_byte = 8'h80; 8'hce: o_byte = 8'hec; 8'hcf: o_byte = 8'h5f;
      8'hd0: o_byte = 8'h60; 8'hd1: o_byte = 8'h51; 8'hd2: o_byte = 8'h7f; 8'hd3: o_byte = 8'ha9;
      8'hd4: o_byte = 8'h19; 8'hd5: o_byte = 8'hb5; 8'hd6: o_byte = 8'h4a; 8'hd7: o_byte = 8'h0d;
      8'hd8: o_byte = 8'h2d; 8'hd9: o_byte = 8'he5; 8'hda: o_byte = 8'h7a; 8'hdb: o_byte = 8'h9f;
      8'hdc: o_byte = 8'h93; 8'hdd: o_byte = 8'hc9; 8'hde: o_byte = 8'h9c; 8'hdf: o_byte = 8'hef;
      8'he0: o_byte = 8'ha0; 8'he1: o_byte = 8'he0; 8'he2: o_byte = 8'h3b; 8'he3: o_byte = 8'h4d;
      8'he4: o_byte = 8'hae; 8'he5: o_byte = 8'h2a; 8'he6: o_byte = 8'hf5; 8'he7: o_byte = 8'hb0;
      8'he8: o_byte = 8'hc8; 8'he9: o_byte = 8'heb; 8'hea: o_byte = 8'hbb; 8'heb: o_byte = 8'h3c;
      8'hec: o_byte = 8'h83; 8'hed: o_byte = 8'h53; 8'hee: o_byte = 8'h99; 8'hef: o_byte = 8'h61;
      8'hf0: o_byte = 8'h17; 8'hf1: o_byte = 8'h2b; 8'hf2: o_byte = 8'h04; 8'hf3: o_byte = 8'h7e;
      8'hf4: o_byte = 8'hba; 8'hf5: o_byte = 8'h77; 8'hf6: o_byte = 8'hd6; 8'hf7: o_byte = 8'h26;
      8'hf8: o_byte = 8'he1; 8'hf9: o_byte = 8'h69; 8'hfa: o_byte = 8'h14; 8'hfb: o_byte = 8'h63;
      8'hfc: o_byte = 8'h55; 8'hfd: o_byte = 8'h21; 8'hfe: o_byte = 8'h0c; 8'hff: o_byte = 8'h7d;
    endcase
  end

endmodule

// File: rtl/inv_substitute_state.sv
// AES InvSubBytes over a 128-bit state, one byte per cycle through a single
// shared inverse S-box.
//
//   state | meaning
//   IDLE  | ready for a new state, outputs not valid
//   BUSY  | substituting byte[r_cnt] each cycle, 16 cycles total
//   DONE  | result valid and held until the consumer takes it
module inv_substitute_state
  import inv_substitute_state_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  inv_sub_state_e     r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [STATE_W-1:0] r_cap;
  logic [STATE_W-1:0] r_out;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [6:0]         w_bit_off;
  logic [BYTE_W-1:0]  w_sbox_in;
  logic [BYTE_W-1:0]  w_sbox_out;

  // Select the byte being processed this cycle from the captured state.
  assign w_bit_off = {r_cnt, 3'b000};
  assign w_sbox_in = r_cap[w_bit_off +: BYTE_W];

  inv_sbox_LUT u_inv_sbox (
    .i_byte (w_sbox_in),
    .o_byte (w_sbox_out)
  );

  // Sequencer: capture, per-byte substitution and output handshake with registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cap       <= '0;
      r_out       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_cap      <= in_state;
            r_cnt      <= '0;
            r_state    <= ST_BUSY;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_BUSY: begin
          r_out[w_bit_off +: BYTE_W] <= w_sbox_out;
          r_cnt <= r_cnt + 1'b1;
          // Last byte written on this edge; the counter wraps back to zero.
          if (r_cnt == CNT_W'(STATE_BYTES - 1)) begin
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_state = r_out;

endmodule

// File: tb/tb_inv_substitute_state.sv
// Self-checking bench for inv_substitute_state: directed vector table, handshake
// corner cases, exhaustive inverse-table sweep and forward/inverse round trips.
module tb_inv_substitute_state;
  import inv_substitute_state_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [127:0] stim;
    logic [127:0] exp;
    string        name;
  } vec_t;

  vec_t vecs [5];

  inv_substitute_state dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept s, check latency/busy, compare result, then release with out_ready.
  task automatic run_xact(input logic [127:0] s, input logic [127:0] exp, input string name,
                          input bit full);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    in_state = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_state = ~s;
    if (full) chk({name, " busy_after_accept"}, {126'd0, busy, in_ready}, 128'd2);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    if (full) chk({name, " latency"}, 128'(lat), 128'd16);
    chk({name, " data"}, out_state, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (full) chk({name, " idle_after_ack"}, {125'd0, out_valid, in_ready, busy}, 128'd2);
  endtask

  function automatic logic [127:0] fwd_state(input logic [127:0] x);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = fwd_sbox(x[8*b +: 8]);
    return r;
  endfunction

  initial begin
    logic [127:0] s;
    logic [127:0] e;
    logic         stable;
    int           cnt;

    vecs[0] = '{128'h00000000000000000000000000000063,
                128'h52525252525252525252525252525200, "single_byte"};
    vecs[1] = '{128'h3052411ee55db4b8f198bfe0ae1127d4,
                128'h0848f8e92a8dc69a2be2f4a0bee33d19, "fips_round1"};
    vecs[2] = '{128'h00000000000000000000000000000000,
                128'h52525252525252525252525252525252, "all_zero"};
    vecs[3] = '{128'hffffffffffffffffffffffffffffffff,
                128'h7d7d7d7d7d7d7d7d7d7d7d7d7d7d7d7d, "all_ff"};
    vecs[4] = '{128'h0f0e0d0c0b0a09080706050403020100,
                128'hfbd7f3819ea340bf38a53630d56a0952, "ramp"};

    // Reset state
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("reset_flags", {125'd0, out_valid, in_ready, busy}, 128'd2);
    chk("reset_out_state", out_state, 128'd0);

    // Reset wins over in_valid in the same cycle
    in_state = 128'h1234;
    in_valid = 1'b1;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("reset_priority", {125'd0, out_valid, in_ready, busy}, 128'd2);

    // out_ready in IDLE has no effect
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    chk("out_ready_idle", {125'd0, out_valid, in_ready, busy}, 128'd2);

    foreach (vecs[i]) run_xact(vecs[i].stim, vecs[i].exp, vecs[i].name, 1'b1);

    // Backpressure: hold result 10 cycles, in_valid pulses ignored
    in_state = vecs[1].stim;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 40) begin tick(); cnt++; end
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_state = 128'(c) * 128'h0101;
      tick();
      if (!out_valid || in_ready || busy || out_state !== vecs[1].exp) stable = 1'b0;
    end
    in_valid = 1'b0;
    chk("backpressure_hold", 128'(stable), 128'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("backpressure_release", {125'd0, out_valid, in_ready, busy}, 128'd2);
    tick();
    chk("no_reaccept_from_pulses", {125'd0, out_valid, in_ready, busy}, 128'd2);

    // Reset at byte 7 of BUSY aborts, then a fresh state processes from byte 0
    in_state = vecs[4].stim;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    chk("midop_busy", 128'(busy), 128'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midop_reset_flags", {125'd0, out_valid, in_ready, busy}, 128'd2);
    chk("midop_reset_out", out_state, 128'd0);
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) stable = 1'b0;
    end
    chk("midop_no_valid", 128'(stable), 128'd1);
    run_xact(vecs[1].stim, vecs[1].exp, "after_abort", 1'b1);

    // Exhaustive inverse table sweep: byte j of block k carries fwd(16k+j)
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) begin
        s[8*j +: 8] = fwd_sbox(8'(16*k + j));
        e[8*j +: 8] = 8'(16*k + j);
      end
      run_xact(s, e, $sformatf("sweep_%0d", k), 1'b0);
    end

    // Random round trips through the forward S-box then this block
    for (int n = 0; n < 1000; n++) begin
      e = {$urandom, $urandom, $urandom, $urandom};
      run_xact(fwd_state(e), e, $sformatf("roundtrip_%0d", n), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
